// File: rtl/i2c_target_regfile_if.sv
// rtl/i2c_target_regfile_if.sv - register-port bundle between the I2C target and local control registers
interface i2c_target_regfile_if;
  logic [7:0] regAddress;
  logic [7:0] regWrData;
  logic       regWrite;
  logic       regRead;
  logic [7:0] regRdData;

  modport master (
    output regAddress,
    output regWrData,
    output regWrite,
    output regRead,
    input  regRdData
  );

  modport slave (
    input  regAddress,
    input  regWrData,
    input  regWrite,
    input  regRead,
    output regRdData
  );
endinterface

// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target mapping bus writes/reads onto an 8-bit register port
module i2c_target_regfile #(
  parameter logic [6:0]  TARGET_ADDRESS = 7'h50,
  parameter int unsigned FILTER_LEN     = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_scl,
  input  logic                  i_sda,
  output logic                  o_sdaDrive,
  output logic                  o_busy,
  i2c_target_regfile_if.master  regPort
);

  // Bus events stay masked until the synchroniser and filter hold real pad samples again.
  localparam logic [3:0] SETTLE_CYCLES = 4'(FILTER_LEN + 3);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RLOAD, RDATA, RACK, IGNORE
  } stateType;

  stateType state, stateNext;

  logic [1:0]            sclSync, sdaSync;
  logic [FILTER_LEN-1:0] sclHist, sdaHist;
  logic                  sclF, sdaF, sclD, sdaD;
  logic [3:0]            settleCnt;
  logic                  eventsOn;
  logic                  sclRise, sclFall, startCond, stopCond;

  logic [7:0] shiftReg;
  logic [3:0] bitCnt;
  logic       rwBit;
  logic       loadPhase;
  logic       sdaDrive;
  logic       busy;
  logic [7:0] regAddress;
  logic [7:0] regWrData;
  logic       regWrite;
  logic       regReadStrobe;
  logic [7:0] byteIn;
  logic       lastBit;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sclSync   <= '1;
      sdaSync   <= '1;
      sclHist   <= '1;
      sdaHist   <= '1;
      sclF      <= 1'b1;
      sdaF      <= 1'b1;
      sclD      <= 1'b1;
      sdaD      <= 1'b1;
      settleCnt <= '0;
    end else begin
      sclSync <= {sclSync[0], i_scl};
      sdaSync <= {sdaSync[0], i_sda};
      sclHist <= {sclHist[FILTER_LEN-2:0], sclSync[1]};
      sdaHist <= {sdaHist[FILTER_LEN-2:0], sdaSync[1]};
      if (&sclHist)
        sclF <= 1'b1;
      else if (!(|sclHist))
        sclF <= 1'b0;
      if (&sdaHist)
        sdaF <= 1'b1;
      else if (!(|sdaHist))
        sdaF <= 1'b0;
      sclD <= sclF;
      sdaD <= sdaF;
      if (settleCnt != SETTLE_CYCLES)
        settleCnt <= settleCnt + 4'd1;
    end
  end

  assign eventsOn  = (settleCnt == SETTLE_CYCLES);
  assign sclRise   = eventsOn & sclF & ~sclD;
  assign sclFall   = eventsOn & ~sclF & sclD;
  assign startCond = eventsOn & sclF & sclD & sdaD & ~sdaF;
  assign stopCond  = eventsOn & sclF & sclD & ~sdaD & sdaF;
  assign byteIn    = {shiftReg[6:0], sdaF};
  assign lastBit   = (bitCnt == 4'd7);

  always_ff @(posedge i_clk) begin
    if (i_reset)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (startCond) begin
      stateNext = ADDR;
    end else if (stopCond) begin
      stateNext = IDLE;
    end else begin
      case (state)
        ADDR:
          if (sclRise && lastBit)
            stateNext = (byteIn[7:1] == TARGET_ADDRESS) ? ADDR_ACK : IGNORE;
        ADDR_ACK: begin
          // A read leaves at the ACK rising edge so the first byte is ready before SCL falls.
          if (sclRise && bitCnt == 4'd1 && rwBit)
            stateNext = RLOAD;
          else if (sclFall && bitCnt == 4'd1 && !rwBit)
            stateNext = PTR;
        end
        PTR:
          if (sclRise && lastBit)
            stateNext = PTR_ACK;
        PTR_ACK, WDATA_ACK:
          if (sclFall && bitCnt == 4'd1)
            stateNext = WDATA;
        WDATA:
          if (sclRise && lastBit)
            stateNext = WDATA_ACK;
        RLOAD:
          if (loadPhase)
            stateNext = RDATA;
        RDATA:
          if (sclFall && bitCnt == 4'd8)
            stateNext = RACK;
        RACK:
          if (sclRise)
            stateNext = sdaF ? IGNORE : RLOAD;
        default: stateNext = state;
      endcase
    end
  end

  always_comb begin
    regReadStrobe = 1'b0;
    if (state == RLOAD && !loadPhase)
      regReadStrobe = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shiftReg   <= '0;
      bitCnt     <= '0;
      rwBit      <= 1'b0;
      loadPhase  <= 1'b0;
      sdaDrive   <= 1'b0;
      busy       <= 1'b0;
      regAddress <= '0;
      regWrData  <= '0;
      regWrite   <= 1'b0;
    end else begin
      regWrite <= 1'b0;
      if (regWrite)
        regAddress <= regAddress + 8'd1;
      if (startCond) begin
        bitCnt    <= '0;
        sdaDrive  <= 1'b0;
        loadPhase <= 1'b0;
      end else if (stopCond) begin
        bitCnt    <= '0;
        sdaDrive  <= 1'b0;
        loadPhase <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA:
            if (sclRise) begin
              shiftReg <= byteIn;
              bitCnt   <= lastBit ? 4'd0 : bitCnt + 4'd1;
              if (lastBit) begin
                if (state == ADDR) begin
                  busy  <= (byteIn[7:1] == TARGET_ADDRESS);
                  rwBit <= byteIn[0];
                end else if (state == PTR) begin
                  regAddress <= byteIn;
                end else begin
                  regWrData <= byteIn;
                  regWrite  <= 1'b1;
                end
              end
            end
          ADDR_ACK, PTR_ACK, WDATA_ACK:
            if (sclFall) begin
              sdaDrive <= (bitCnt == 4'd0);
              bitCnt   <= (bitCnt == 4'd0) ? 4'd1 : 4'd0;
            end
          RLOAD:
            if (!loadPhase) begin
              loadPhase <= 1'b1;
            end else begin
              loadPhase <= 1'b0;
              shiftReg  <= regPort.regRdData;
              bitCnt    <= '0;
            end
          RDATA:
            if (sclFall) begin
              if (bitCnt == 4'd8) begin
                sdaDrive <= 1'b0;
                bitCnt   <= '0;
              end else begin
                sdaDrive <= ~shiftReg[7];
                shiftReg <= {shiftReg[6:0], 1'b0};
                bitCnt   <= bitCnt + 4'd1;
              end
            end
          RACK:
            if (sclRise && !sdaF)
              regAddress <= regAddress + 8'd1;
          default: ;
        endcase
      end
    end
  end

  assign o_sdaDrive         = sdaDrive;
  assign o_busy             = busy;
  assign regPort.regAddress = regAddress;
  assign regPort.regWrData  = regWrData;
  assign regPort.regWrite   = regWrite;
  assign regPort.regRead    = regReadStrobe;

endmodule
